// File: rtl/mcycle_controller.sv
// rtl/mcycle_controller.sv - multicycle RV32I sequencer driving the shared-ALU, unified-memory datapath
// Moore FSM with memory wait states; enables are forced low while rst is held.
module mcycle_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [3:0]  alu_flags,
   input  logic        mem_rdy,
   output logic        pc_we,
   output logic        ir_we,
   output logic        adr_src,
   output logic        mem_we,
   output logic        reg_we,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [2:0]  imm_src,
   output logic [3:0]  alu_ctrl,
   output logic        instr_done,
   output logic        halt
);
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
      S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JUMP, S_HALT
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2,
                          IMM_U = 3'd3, IMM_J = 3'd4, IMM_I2 = 3'd5;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                          ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                          ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                          ALU_AND = 4'd9;

   state_t state, next;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic       f7_nz, neg, zero, cout, ov;
   logic       taken, br_ok;
   logic [3:0] op_alu;
   logic       unused_bits;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7_nz  = |instr[31:25];
   assign {neg, zero, cout, ov} = alu_flags;
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   // Flags come from rs1 - rs2 computed in BRANCH.
   always_comb begin
      taken = 1'b0;
      br_ok = 1'b1;
      case (f3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = neg ^ ov;
         3'b101:  taken = ~(neg ^ ov);
         3'b110:  taken = ~cout;
         3'b111:  taken = cout;
         default: br_ok = 1'b0;
      endcase
   end

   always_comb begin
      op_alu = ALU_ADD;
      case (f3)
         3'b000:  op_alu = (opcode == OP_R && f7_nz) ? ALU_SUB : ALU_ADD;
         3'b001:  op_alu = ALU_SLL;
         3'b010:  op_alu = ALU_SLT;
         3'b011:  op_alu = ALU_SLTU;
         3'b100:  op_alu = ALU_XOR;
         3'b101:  op_alu = f7_nz ? ALU_SRA : ALU_SRL;
         3'b110:  op_alu = ALU_OR;
         default: op_alu = ALU_AND;
      endcase
   end

   always_comb begin
      next = state;
      case (state)
         S_FETCH:    next = mem_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next = S_MEM_ADR;
               OP_R:              next = S_EXEC_R;
               OP_I:              next = S_EXEC_I;
               OP_BR:             next = S_BRANCH;
               OP_JAL:            next = S_JUMP;
               OP_JALR:           next = S_JALR_ADR;
               OP_AUIPC:          next = S_ALU_WB;
               default:           next = S_HALT;
            endcase
         end
         S_MEM_ADR:  next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   next = mem_rdy ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   next = mem_rdy ? S_FETCH : S_MEM_WR;
         S_EXEC_R,
         S_EXEC_I:   next = S_ALU_WB;
         S_BRANCH:   next = br_ok ? S_FETCH : S_HALT;
         S_JALR_ADR: next = S_JUMP;
         S_JUMP:     next = S_ALU_WB;
         S_HALT:     next = S_HALT;
         default:    next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         halt  <= 1'b0;
      end else begin
         state <= next;
         if (next == S_HALT) halt <= 1'b1;
      end
   end

   always_comb begin
      pc_we = 1'b0; ir_we = 1'b0; adr_src = 1'b0; mem_we = 1'b0; reg_we = 1'b0;
      alu_src_a = 2'd0; alu_src_b = 2'd0; result_src = 2'd0;
      alu_ctrl = ALU_ADD; instr_done = 1'b0;
      case (opcode)
         OP_LOAD, OP_JALR: imm_src = IMM_I;
         OP_STORE:         imm_src = IMM_S;
         OP_BR:            imm_src = IMM_B;
         OP_JAL:           imm_src = IMM_J;
         OP_AUIPC:         imm_src = IMM_U;
         OP_I:             imm_src = (f3 == 3'b001 || f3 == 3'b101) ? IMM_I2 : IMM_I;
         default:          imm_src = IMM_I;
      endcase
      case (state)
         S_FETCH: begin
            alu_src_b = 2'd2; result_src = 2'd2;
            ir_we = mem_rdy; pc_we = mem_rdy;
         end
         S_DECODE:   begin alu_src_a = 2'd1; alu_src_b = 2'd1; end
         S_MEM_ADR,
         S_JALR_ADR: begin alu_src_a = 2'd2; alu_src_b = 2'd1; end
         S_MEM_RD:   adr_src = 1'b1;
         S_MEM_WB:   begin result_src = 2'd1; reg_we = 1'b1; instr_done = 1'b1; end
         S_MEM_WR:   begin adr_src = 1'b1; mem_we = 1'b1; instr_done = mem_rdy; end
         S_EXEC_R:   begin alu_src_a = 2'd2; alu_ctrl = op_alu; end
         S_EXEC_I:   begin alu_src_a = 2'd2; alu_src_b = 2'd1; alu_ctrl = op_alu; end
         S_ALU_WB:   begin reg_we = 1'b1; instr_done = 1'b1; end
         S_BRANCH: begin
            alu_src_a = 2'd2; alu_ctrl = ALU_SUB;
            pc_we = taken & br_ok; instr_done = 1'b1;
         end
         S_JUMP:     begin pc_we = 1'b1; alu_src_a = 2'd1; alu_src_b = 2'd2; end
         default:    ;
      endcase
      if (rst) begin
         pc_we = 1'b0; ir_we = 1'b0; mem_we = 1'b0; reg_we = 1'b0; instr_done = 1'b0;
      end
   end
endmodule

// File: doc/mcycle_controller.md
# mcycle_controller

Multicycle sequencer for the RV32I datapath: one shared ALU and one unified instruction/data memory, used over several cycles per instruction. A Moore FSM with memory wait-state handshaking drives every datapath enable and mux select, and latches a sticky halt on illegal opcodes. It replaces the single-cycle decoder when the core is built in multicycle configuration.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  instruction register contents (valid from DECODE on).
- alu_flags  in  4  {neg, zero, cout, ov} from the combinational ALU.
- mem_rdy  in  1  memory has completed the current access this cycle.
- pc_we  out  1  PC load (PC <= result bus).
- ir_we  out  1  instruction register and old-PC register load.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_we  out  1  memory write strobe.
- reg_we  out  1  register file write (wd = result bus).
- alu_src_a  out  2  0 = PC, 1 = old PC, 2 = rs1.
- alu_src_b  out  2  0 = rs2, 1 = extended immediate, 2 = constant 4.
- result_src  out  2  0 = ALUOut register, 1 = read data, 2 = ALU result (direct).
- imm_src  out  3  immediate format, codebase imm_src_e encoding.
- alu_ctrl  out  4  codebase alu_op_e encoding.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
- halt  out  1  sticky; illegal opcode seen.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JALR_ADR, JUMP, HALT.
- FETCH: adr_src=0, a=PC, b=4, ADD, result_src=2. ir_we=pc_we=mem_rdy. Stays while !mem_rdy; goes to DECODE when mem_rdy.
- DECODE: a=old PC, b=imm, ADD (ALUOut <= branch/jump/auipc target). imm_src is set by opcode: load/jalr=I, store=S, branch=B, jal=J, auipc=U, shift-imm=ITYPE2, otherwise ITYPE.
- DECODE next state by opcode: load/store->MEM_ADR, R->EXEC_R, I->EXEC_I, B->BRANCH, jal->JUMP, jalr->JALR_ADR, auipc->ALU_WB, other->HALT.
- MEM_ADR: a=rs1, b=imm, ADD. Goes to MEM_RD for load, MEM_WR for store.
- MEM_RD: adr_src=1. Waits for mem_rdy, then goes to MEM_WB.
- MEM_WB: result_src=1, reg_we=1, then FETCH.
- MEM_WR: adr_src=1, mem_we=1 held until mem_rdy, then FETCH.
- EXEC_R: a=rs1, b=rs2. EXEC_I: a=rs1, b=imm. alu_ctrl comes from func3/func7 (SUB/SRA when func7≠0, R-type only for SUB). Both go to ALU_WB.
- ALU_WB: result_src=0, reg_we=1, then FETCH.
- BRANCH: a=rs1, b=rs2, SUB, result_src=0. pc_we = taken, then FETCH.
  - beq: zero. bne: !zero.
  - blt: neg^ov. bge: !(neg^ov).
  - bltu: !cout. bgeu: cout.
  - Illegal func3 (010/011) -> HALT.
- JALR_ADR: a=rs1, b=imm, ADD (ALUOut <= target), then JUMP.
- JUMP: result_src=0, pc_we=1. ALU computes old PC+4 (a=1, b=2, ADD). Then ALU_WB.
- HALT: all enables 0, halt=1. Left only by rst.
- Outputs not listed for a state are 0. Selects not listed are don't-care.

## Timing
- Reset (asynchronous): state=FETCH, halt=0, instr_done=0. During reset, pc_we=ir_we=mem_we=reg_we=0, regardless of mem_rdy.
- Cycles per instruction with zero wait states:
  - load: 5 (FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB).
  - store: 4.
  - R/I: 4.
  - branch: 3.
  - jal: 4.
  - jalr: 5.
  - auipc: 3.
- Each cycle with mem_rdy=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Outputs hold constant while waiting.
- instr_done is asserted in:
  - MEM_WB, ALU_WB and BRANCH;
  - MEM_WR when mem_rdy=1.
- rst mid-instruction aborts it. No partial write is issued after rst deasserts.

## Test plan
- Reset, then mem_rdy=1, fetch `add x3,x1,x2` (0x002081B3) -> states FETCH,DECODE,EXEC_R,ALU_WB; reg_we only in cycle 4; alu_ctrl=ADD; instr_done pulses once.
- `lw x5,8(x1)` with mem_rdy low for 2 cycles in MEM_RD -> 7-cycle instruction; adr_src=1 throughout the wait; reg_we with result_src=1 in last cycle.
- `sw`, then `beq` with flags zero=1 and then zero=0 -> mem_we held until mem_rdy; pc_we=1 in BRANCH only when taken; bltu with cout=0 -> taken.
- `jalr x1,4(x2)` -> 5 cycles; pc_we in JUMP with result_src=0; reg_we in ALU_WB.
- Opcode 0x7F -> HALT after DECODE; halt=1 with all enables 0 indefinitely; rst clears halt and returns to FETCH.
- Assert rst during MEM_WR with mem_rdy=0 -> mem_we drops immediately; FETCH on release.
